sar_search: RTL and testbench

Successive-approximation search controller that drives the X operand of an external combinational magnitude comparator and reads back its one-hot {greater, equal, less} result. It binary-searches an unknown WIDTH-bit value applied to the comparator's Y operand, reporting it on `found` with a single-cycle `done` pulse. It is the sequential consumer of the comparator's result bus and the producer of its X operand.

---
 rtl/sar_search.sv | 159 +++++++++++++++
 tb/tb_sar_search.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
//
// Binary-searches an unknown WIDTH-bit value sitting on the Y operand of an external
// combinational magnitude comparator. The controller drives the comparator's X operand
// (guess) and reads back its one-hot {greater, equal, less} result (cmp_o) every cycle
// while busy. A match is reported on found with a one-cycle done pulse. A bound
// violation or a malformed comparator code aborts with a one-cycle err pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a search (only honoured in IDLE)
//   cmp_o  in   comparator result for current guess: [2] >, [1] ==, [0] <
//   guess  out  registered probe value, drives comparator X
//   busy   out  high while probing
//   done   out  one-cycle pulse, match found
//   err    out  one-cycle pulse, search aborted
//   found  out  last matched value, held until the next done
//   steps  out  probe count of the last search (only with SAR_STEP_COUNT_EN)
//
// Optional feature macro: SAR_STEP_COUNT_EN adds the steps port and its counter.

module sar_search #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [2:0]                  cmp_o,
    output logic [WIDTH-1:0]            guess,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [WIDTH-1:0]            found
`ifdef SAR_STEP_COUNT_EN
    ,
    output logic [$clog2(WIDTH+2)-1:0]  steps
`endif
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StProbe = 1'b1;

    localparam logic [WIDTH-1:0] GUESS_INIT = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X      = (WIDTH + 1)'(1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

`ifdef SAR_STEP_COUNT_EN
    localparam int unsigned STEP_W = $clog2(WIDTH + 2);
    logic [STEP_W-1:0] steps_q, steps_d;
`endif

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        found_d = found_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef SAR_STEP_COUNT_EN
        steps_d = steps_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = '1;
                    guess_d = GUESS_INIT;
                    state_d = StProbe;
`ifdef SAR_STEP_COUNT_EN
                    steps_d = '0;
`endif
                end
            end
            StProbe: begin
`ifdef SAR_STEP_COUNT_EN
                steps_d = steps_q + STEP_W'(1);
`endif
                case (cmp_o)
                    3'b010: begin
                        found_d = guess_q;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                    3'b100: begin
                        if (guess_q == lo_q) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            hi_d    = guess_q - ONE_W;
                            // Sum is WIDTH+1 bits so the carry survives the halving.
                            guess_d = WIDTH'(({1'b0, lo_q} + {1'b0, guess_q} - ONE_X) >> 1);
                        end
                    end
                    3'b001: begin
                        if (guess_q == hi_q) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            lo_d    = guess_q + ONE_W;
                            guess_d = WIDTH'(({1'b0, guess_q} + ONE_X + {1'b0, hi_q}) >> 1);
                        end
                    end
                    default: begin
                        // Zero or multiple flags set: comparator result is unusable.
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            guess_q <= '0;
            lo_q    <= '0;
            hi_q    <= '1;
            found_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SAR_STEP_COUNT_EN
            steps_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            guess_q <= guess_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            found_q <= found_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SAR_STEP_COUNT_EN
            steps_q <= steps_d;
`endif
        end
    end

    assign guess = guess_q;
    assign busy  = (state_q == StProbe);
    assign done  = done_q;
    assign err   = err_q;
    assign found = found_q;
`ifdef SAR_STEP_COUNT_EN
    assign steps = steps_q;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Directed testbench for sar_search (WIDTH=3) with a behavioural comparator model.
module tb_sar_search;

    localparam int unsigned WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       cmp_o;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] found;
`ifdef SAR_STEP_COUNT_EN
    logic [2:0]       steps;
`endif

    // Comparator model, with an override for fault injection.
    logic [WIDTH-1:0] target;
    logic             force_en;
    logic [2:0]       force_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        cmp_o = 3'b001;
        if (force_en)             cmp_o = force_code;
        else if (guess > target)  cmp_o = 3'b100;
        else if (guess == target) cmp_o = 3'b010;
        else                      cmp_o = 3'b001;
    end

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cmp_o (cmp_o),
        .guess (guess),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .found (found)
`ifdef SAR_STEP_COUNT_EN
        ,
        .steps (steps)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; target = '0; force_en = 1'b0; force_code = 3'b000;
        #2;
        total++;
        if (guess !== 3'd0 || found !== 3'd0) begin
            bad++; $display("FAIL reset_values: guess=%0d found=%0d want 0/0", guess, found);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: busy=%b done=%b err=%b want 000", busy, done, err);
        end
`ifdef SAR_STEP_COUNT_EN
        total++;
        if (steps !== 3'd0) begin bad++; $display("FAIL reset_steps: got %0d want 0", steps); end
`endif
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Runs one search; seq holds the expected guesses, 3 bits each, first in [2:0].
    task automatic test_search(input logic [WIDTH-1:0] tgt, input logic [11:0] seq,
                               input int n, input string name);
        target = tgt; force_en = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (guess !== seq[k*3 +: 3] || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s probe%0d: guess=%0d busy=%b done=%b want %0d/1/0",
                         name, k, guess, busy, done, seq[k*3 +: 3]);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL %s done: done=%b busy=%b err=%b want 1/0/0", name, done, busy, err);
        end
        total++;
        if (found !== tgt) begin bad++; $display("FAIL %s found: got %0d want %0d", name, found, tgt); end
`ifdef SAR_STEP_COUNT_EN
        total++;
        if (steps !== 3'(n)) begin bad++; $display("FAIL %s steps: got %0d want %0d", name, steps, n); end
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse: got %b want 0", name, done); end
    endtask

    task automatic test_err_code();
        force_en = 1'b1; force_code = 3'b110;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        total++;
        if (guess !== 3'd3 || busy !== 1'b1) begin
            bad++; $display("FAIL err_code probe: guess=%0d busy=%b want 3/1", guess, busy);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL err_code flags: err=%b done=%b busy=%b want 1/0/0", err, done, busy);
        end
        total++;
        if (found !== 3'd7) begin bad++; $display("FAIL err_code found: got %0d want 7", found); end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_code pulse: got %b want 0", err); end
        force_en = 1'b0;
    endtask

    // Forces a constant direction until guess hits a bound and the search aborts.
    task automatic test_err_bound(input logic [2:0] code, input logic [11:0] seq,
                                  input int n, input string name);
        force_en = 1'b1; force_code = code;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (guess !== seq[k*3 +: 3]) begin
                bad++; $display("FAIL %s probe%0d: got %0d want %0d", name, k, guess, seq[k*3 +: 3]);
            end
        end
        @(negedge clk);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s flags: err=%b done=%b busy=%b want 1/0/0", name, err, done, busy);
        end
`ifdef SAR_STEP_COUNT_EN
        total++;
        if (steps !== 3'(n)) begin bad++; $display("FAIL %s steps: got %0d want %0d", name, steps, n); end
`endif
        @(negedge clk);
        total++;
        if (err !== 1'b0 || guess !== seq[(n-1)*3 +: 3] || found !== 3'd7) begin
            bad++;
            $display("FAIL %s idle_hold: err=%b guess=%0d found=%0d want 0/%0d/7",
                     name, err, guess, found, seq[(n-1)*3 +: 3]);
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        target = 3'd6;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        total++;
        if (guess !== 3'd5) begin bad++; $display("FAIL reset_mid probe2: got %0d want 5", guess); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (guess !== 3'd0 || found !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid values: guess=%0d found=%0d busy=%b done=%b err=%b want 0",
                     guess, found, busy, done, err);
        end
        @(negedge clk) rst_n = 1'b1;
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_mid no_pulse: done=%b err=%b want 0/0", done, err);
        end
    endtask

    task automatic test_back_to_back();
        target = 3'd5;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        total++;
        if (guess !== 3'd3) begin bad++; $display("FAIL b2b probe1: got %0d want 3", guess); end
        @(negedge clk);
        total++;
        if (guess !== 3'd5) begin bad++; $display("FAIL b2b probe2: got %0d want 5", guess); end
        // start stays high through the next edge, where it must be ignored mid-search.
        @(negedge clk);
        total++;
        if (done !== 1'b1 || found !== 3'd5) begin
            bad++; $display("FAIL b2b done1: done=%b found=%0d want 1/5", done, found);
        end
        target = 3'd3;
        @(negedge clk) start = 1'b0;
        total++;
        if (guess !== 3'd3 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b restart: guess=%0d busy=%b done=%b want 3/1/0", guess, busy, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || found !== 3'd3) begin
            bad++; $display("FAIL b2b done2: done=%b found=%0d want 1/3", done, found);
        end
`ifdef SAR_STEP_COUNT_EN
        total++;
        if (steps !== 3'd1) begin bad++; $display("FAIL b2b steps: got %0d want 1", steps); end
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL b2b done_pulse: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_search(3'd5, {3'd0, 3'd0, 3'd5, 3'd3}, 2, "t5");
        test_search(3'd0, {3'd0, 3'd0, 3'd1, 3'd3}, 3, "t0");
        test_search(3'd7, {3'd7, 3'd6, 3'd5, 3'd3}, 4, "t7");
        test_err_code();
        test_err_bound(3'b100, {3'd0, 3'd0, 3'd1, 3'd3}, 3, "err_lo");
        test_err_bound(3'b001, {3'd7, 3'd6, 3'd5, 3'd3}, 4, "err_hi");
        test_reset_mid();
        test_search(3'd6, {3'd0, 3'd6, 3'd5, 3'd3}, 3, "t6");
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
